// File: rtl/alu_op_sequencer.sv
// One-request-at-a-time sequencer in front of a combinational ALU: latch, settle, capture, respond.
// Optional illegal-opcode trap enabled by defining ALU_ILLEGAL_TRAP_EN.
module alu_op_sequencer #(
    parameter int SINGLE_LAT = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] done_count
);
    localparam int MAX_LAT = (SINGLE_LAT > MULDIV_LAT) ? SINGLE_LAT : MULDIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] SG_CNT = CW'(SINGLE_LAT - 1);
    localparam logic [CW-1:0] MD_CNT = CW'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [15:0]   done_cnt;
    logic          op_legal, op_muldiv, accept;
    logic [CW-1:0] lat_m1;

    function automatic logic is_legal(input logic [4:0] op);
        return (op == 5'd0) || (op >= 5'd3 && op <= 5'd11) || (op >= 5'd15 && op <= 5'd18);
    endfunction

    assign op_legal   = is_legal(req_op);
    assign op_muldiv  = (req_op == 5'b01111) || (req_op == 5'b10000);
    assign lat_m1     = op_muldiv ? MD_CNT : SG_CNT;
    assign req_ready  = (state_q == IDLE);
    assign busy       = !req_ready;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = (state_q == RESP);
    assign done_count = done_cnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) begin
`ifdef ALU_ILLEGAL_TRAP_EN
                state_d = op_legal ? EXEC : RESP;
`else
                state_d = EXEC;
`endif
            end
            EXEC: if (cnt_q == '0) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    logic rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_op   <= 5'b00000;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_hi   <= '0;
            rsp_lo   <= '0;
            done_cnt <= '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
`ifdef ALU_ILLEGAL_TRAP_EN
                    // Trapped opcodes never reach the ALU; inputs keep the previous op.
                    rsp_err_q <= !op_legal;
                    if (op_legal) begin
                        alu_op <= req_op;
                        alu_a  <= req_a;
                        alu_b  <= req_b;
                        cnt_q  <= lat_m1;
                    end else begin
                        rsp_hi <= '0;
                        rsp_lo <= '0;
                    end
`else
                    // Illegal opcodes degrade to ld, so the ALU returns operand B.
                    alu_op <= op_legal ? req_op : 5'b00000;
                    alu_a  <= req_a;
                    alu_b  <= req_b;
                    cnt_q  <= lat_m1;
`endif
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        rsp_hi <= alu_c[63:32];
                        rsp_lo <= alu_c[31:0];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: if (rsp_ready) done_cnt <= done_cnt + 16'd1;
                default: ;
            endcase
        end
    end
endmodule
